vga_sync_monitor: RTL
=====================

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_SYNC, default 96, hsync low width in clocks; H_BACK, default 48, back porch; H_TOTAL, default 800, clocks per line.
REQ-003 The block SHALL have parameter V_ACTIVE, default 480, visible lines; V_SYNC, default 2, vsync low width in lines; V_BACK, default 33; V_TOTAL, default 525, lines per frame.
REQ-004 The block SHALL have parameter LOCK_FRAMES, default 2, consecutive clean frames required to lock.
REQ-005 Port: vga_clk  input  1  pixel clock; the only clock.
REQ-006 Port: rst  input  1  asynchronous, active-low reset.
REQ-007 Port: h_sync  input  1  horizontal sync, active-low pulse.
REQ-008 Port: v_sync  input  1  vertical sync, active-low pulse.
REQ-009 Port: clr_err  input  1  one-cycle pulse that clears sticky error flags.
REQ-010 Port: locked  output  1  timing matches the parameters.
REQ-011 Port: rx_active  output  1  current clock is a visible pixel, valid only while locked.
REQ-012 Port: rx_x / rx_y  output  10 each  reconstructed pixel coordinates.
REQ-013 Port: frame_count  output  16  frames received while locked.
REQ-014 Port: h_err / v_err  output  1 each  sticky horizontal / vertical timing violation.

Function
REQ-015 h_sync and v_sync SHALL be registered once (hs_q, vs_q); falling edge = q high and input low; rising edge = q low and input high.
REQ-016 The line counter h_cnt (11 bits) SHALL load 0 on an hsync falling edge, otherwise increment, saturating at 2047.
REQ-017 On each hsync falling edge the block SHALL check h_cnt+1 == H_TOTAL; on each hsync rising edge it SHALL check the low width == H_SYNC; any failure is a horizontal mismatch.
REQ-018 The line counter v_cnt (10 bits) SHALL advance only on hsync falling edges, load 0 when v_sync is low at an hsync falling edge and vs_q was high, and saturate at 1023.
REQ-019 The block SHALL check V_TOTAL lines between vsync falling edges and V_SYNC lines of low width; any failure is a vertical mismatch.
REQ-020 FSM states SHALL be SEARCH (reset), MEASURE and LOCKED.
REQ-021 SEARCH SHALL go to MEASURE on the first vsync falling edge, with the good-frame count cleared.
REQ-022 MEASURE SHALL increment the good-frame count at each vsync falling edge of a frame with no mismatch, and go to LOCKED when the count reaches LOCK_FRAMES.
REQ-023 MEASURE SHALL return to SEARCH on any mismatch.
REQ-024 LOCKED SHALL go to SEARCH in the cycle after a mismatch and set the corresponding sticky error flag; a frame boundary coincident with a mismatch is not counted.
REQ-025 locked SHALL be 1 exactly when the state is LOCKED (registered output).
REQ-026 rx_active SHALL be 1 when locked, H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE.
REQ-027 rx_x = h_cnt-(H_SYNC+H_BACK) and rx_y = v_cnt-(V_SYNC+V_BACK), truncated to 10 bits; both SHALL be 0 whenever rx_active is 0.
REQ-028 frame_count SHALL increment on each vsync falling edge while in LOCKED, wrapping from 65535 to 0; it is held, not cleared, when lock is lost.
REQ-029 clr_err SHALL clear h_err and v_err; if a set and a clear occur in the same cycle, the set wins.
REQ-030 Errors SHALL be flagged only in the LOCKED state; a mismatch in MEASURE only restarts locking.

Reset
REQ-031 With rst low, all outputs, counters, the FSM (SEARCH) and the sync registers (hs_q = vs_q = 1) SHALL reset asynchronously; deassertion mid-frame restarts in SEARCH.

Structure
REQ-032 Package vga_timing_pkg SHALL hold the 640x480 default constants and the FSM state enum.
REQ-033 Sub-module sync_meter (edge detector plus period and width counter with count-enable input) SHALL be instantiated twice: horizontal with enable = 1, vertical with enable = hsync falling edge.

Verification
REQ-034 Clean 640x480 sync stream -> locked rises in the cycle after the 3rd vsync falling edge; h_err = v_err = 0.
REQ-035 While locked, check the first visible pixel -> rx_active = 1, rx_x = 0, rx_y = 0 at h_cnt = 144, v_cnt = 35; at the last visible pixel rx_x = 639, rx_y = 479.
REQ-036 While locked, one line of 801 clocks -> locked = 0 the next cycle, h_err = 1 and stays set; clr_err pulse -> h_err = 0; relock after 2 clean frames.
REQ-037 vsync width of 3 lines during MEASURE -> return to SEARCH, v_err stays 0, locked stays 0.
REQ-038 Preload frame_count to 65535 (force) -> next locked frame gives 0; clr_err coincident with a new mismatch -> flag remains 1.
REQ-039 rst asserted mid-line while locked -> all outputs 0 immediately; after release, relock after LOCK_FRAMES clean frames.

Source files
------------

// File: rtl/vga_sync_monitor_pkg.sv
// Shared timing constants, counter widths and monitor state encoding for the
// VGA sync monitor. The defaults describe standard 640x480 at 60 Hz.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF    = 640;
    localparam int unsigned H_SYNC_DEF      = 96;
    localparam int unsigned H_BACK_DEF      = 48;
    localparam int unsigned H_TOTAL_DEF     = 800;
    localparam int unsigned V_ACTIVE_DEF    = 480;
    localparam int unsigned V_SYNC_DEF      = 2;
    localparam int unsigned V_BACK_DEF      = 33;
    localparam int unsigned V_TOTAL_DEF     = 525;
    localparam int unsigned LOCK_FRAMES_DEF = 2;

    localparam int unsigned H_CNT_W = 11;
    localparam int unsigned V_CNT_W = 10;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned FRAME_W = 16;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_e;

    // True when lo <= cnt < lo + len.
    function automatic logic in_window(input logic [31:0] cnt,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (cnt >= lo) && (cnt < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_monitor_if.sv
// Sync inputs, error-clear and reconstructed-timing outputs of the monitor.
// The source side (video generator / bench) is master, the monitor is slave.
interface vga_sync_monitor_if;
    import vga_timing_pkg::*;

    logic               h_sync;
    logic               v_sync;
    logic               clr_err;
    logic               locked;
    logic               rx_active;
    logic [COORD_W-1:0] rx_x;
    logic [COORD_W-1:0] rx_y;
    logic [FRAME_W-1:0] frame_count;
    logic               h_err;
    logic               v_err;

    modport master (
        output h_sync, v_sync, clr_err,
        input  locked, rx_active, rx_x, rx_y, frame_count, h_err, v_err
    );

    modport slave (
        input  h_sync, v_sync, clr_err,
        output locked, rx_active, rx_x, rx_y, frame_count, h_err, v_err
    );

endinterface

// File: rtl/vga_sync_monitor_sync_meter.sv
// Active-low sync pulse meter: edge detect, saturating position counter and
// period / low-width checks, all advancing only when i_en is high.
module sync_meter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W  = H_CNT_W,
    parameter int unsigned PERIOD = H_TOTAL_DEF,
    parameter int unsigned WIDTH  = H_SYNC_DEF
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic             i_sync,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_fall,
    output logic             o_period_bad,
    output logic             o_width_bad
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_sync_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fall;
    logic             w_rise;
    logic [31:0]      w_len;

    // The sync register runs every clock; only the edge events are gated, so a
    // vertical edge counts only when it lines up with an hsync falling edge.
    assign w_fall = i_en & r_sync_q & ~i_sync;
    assign w_rise = i_en & ~r_sync_q & i_sync;
    assign w_len  = 32'(r_cnt) + 32'd1;

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            r_sync_q <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_sync_q <= i_sync;
            if (w_fall) begin
                r_cnt <= '0;
            end else if (i_en && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cnt        = r_cnt;
    assign o_fall       = w_fall;
    assign o_period_bad = w_fall & (w_len != PERIOD);
    assign o_width_bad  = w_rise & (w_len != WIDTH);

endmodule

// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: measures hsync/vsync timing against the configured mode,
// locks after clean frames and reconstructs visible pixel coordinates.
//
// state   | meaning
// SEARCH  | waiting for a vsync falling edge to start measuring
// MEASURE | counting consecutive clean frames toward lock
// LOCKED  | timing matches; coordinates valid, frames counted, errors flagged
module vga_sync_monitor
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BACK      = H_BACK_DEF,
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BACK      = V_BACK_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic              vga_clk,
    input  logic              rst,
    vga_sync_monitor_if.slave bus
);

    localparam int unsigned GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam int unsigned H_VIS0 = H_SYNC + H_BACK;
    localparam int unsigned V_VIS0 = V_SYNC + V_BACK;

    logic [H_CNT_W-1:0] w_h_cnt;
    logic [V_CNT_W-1:0] w_v_cnt;
    logic               w_h_fall;
    logic               w_v_fall;
    logic               w_h_period_bad;
    logic               w_h_width_bad;
    logic               w_v_period_bad;
    logic               w_v_width_bad;
    logic               w_h_bad;
    logic               w_v_bad;
    logic               w_bad;
    logic [31:0]        w_good_next;
    logic               w_rx_active;
    logic [COORD_W-1:0] w_rx_x;
    logic [COORD_W-1:0] w_rx_y;

    mon_state_e         r_state;
    logic [GOOD_W-1:0]  r_good_cnt;
    logic               r_locked;
    logic [FRAME_W-1:0] r_frame_count;
    logic               r_h_err;
    logic               r_v_err;

    sync_meter #(
        .CNT_W  (H_CNT_W),
        .PERIOD (H_TOTAL),
        .WIDTH  (H_SYNC)
    ) u_h_meter (
        .vga_clk      (vga_clk),
        .rst          (rst),
        .i_sync       (bus.h_sync),
        .i_en         (1'b1),
        .o_cnt        (w_h_cnt),
        .o_fall       (w_h_fall),
        .o_period_bad (w_h_period_bad),
        .o_width_bad  (w_h_width_bad)
    );

    // Vertical timing is measured in lines, so it steps on hsync falling edges.
    sync_meter #(
        .CNT_W  (V_CNT_W),
        .PERIOD (V_TOTAL),
        .WIDTH  (V_SYNC)
    ) u_v_meter (
        .vga_clk      (vga_clk),
        .rst          (rst),
        .i_sync       (bus.v_sync),
        .i_en         (w_h_fall),
        .o_cnt        (w_v_cnt),
        .o_fall       (w_v_fall),
        .o_period_bad (w_v_period_bad),
        .o_width_bad  (w_v_width_bad)
    );

    assign w_h_bad     = w_h_period_bad | w_h_width_bad;
    assign w_v_bad     = w_v_period_bad | w_v_width_bad;
    assign w_bad       = w_h_bad | w_v_bad;
    assign w_good_next = 32'(r_good_cnt) + 32'd1;

    // Clears are applied first so that a same-cycle set below takes priority.
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            r_state       <= SEARCH;
            r_good_cnt    <= '0;
            r_locked      <= 1'b0;
            r_frame_count <= '0;
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
        end else begin
            r_h_err <= r_h_err & ~bus.clr_err;
            r_v_err <= r_v_err & ~bus.clr_err;
            case (r_state)
                SEARCH: begin
                    if (w_v_fall) begin
                        r_state    <= MEASURE;
                        r_good_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (w_bad) begin
                        r_state <= SEARCH;
                    end else if (w_v_fall) begin
                        r_good_cnt <= r_good_cnt + GOOD_W'(1);
                        if (w_good_next >= LOCK_FRAMES) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_bad) begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        if (w_h_bad) r_h_err <= 1'b1;
                        if (w_v_bad) r_v_err <= 1'b1;
                    end else if (w_v_fall) begin
                        r_frame_count <= r_frame_count + FRAME_W'(1);
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign w_rx_active = r_locked
                       & in_window(32'(w_h_cnt), H_VIS0, H_ACTIVE)
                       & in_window(32'(w_v_cnt), V_VIS0, V_ACTIVE);
    assign w_rx_x      = w_h_cnt[COORD_W-1:0] - COORD_W'(H_VIS0);
    assign w_rx_y      = w_v_cnt[COORD_W-1:0] - COORD_W'(V_VIS0);

    assign bus.locked      = r_locked;
    assign bus.rx_active   = w_rx_active;
    assign bus.rx_x        = w_rx_active ? w_rx_x : '0;
    assign bus.rx_y        = w_rx_active ? w_rx_y : '0;
    assign bus.frame_count = r_frame_count;
    assign bus.h_err       = r_h_err;
    assign bus.v_err       = r_v_err;

endmodule
